// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, digit-scan patterns and BCD helpers for the
// sequence-detector display stage.
package seg7_pkg;

  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] DIG_ONES  = 2'd0;
  localparam logic [IDX_W-1:0] DIG_TENS  = 2'd1;
  localparam logic [IDX_W-1:0] DIG_HUNDS = 2'd2;
  localparam logic [IDX_W-1:0] DIG_STATE = 2'd3;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Letter codes share the decoder's 4-bit code space above the BCD digits
  localparam logic [3:0] CODE_A = 4'd10;
  localparam logic [3:0] CODE_B = 4'd11;
  localparam logic [3:0] CODE_C = 4'd12;
  localparam logic [3:0] CODE_D = 4'd13;
  localparam logic [3:0] CODE_E = 4'd14;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  function automatic logic [3:0] an_pattern(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    if (!cin) return d;
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seq_display_if.sv
// Detector-side strobes and display-side outputs of the seq_display stage.
interface seq_display_if;
  logic        step;
  logic        z;
  logic [4:0]  State;
  logic        clr;
  logic [11:0] det_count;
  logic        state_err;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output step, z, State, clr,
    input  det_count, state_err, seg, an, dp
  );

  modport slave (
    input  step, z, State, clr,
    output det_count, state_err, seg, an, dp
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit/letter to active-low segment decoder; blank wins over dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        CODE_A:  seg = SEG_A;
        CODE_B:  seg = SEG_B;
        CODE_C:  seg = SEG_C;
        CODE_D:  seg = SEG_D;
        CODE_E:  seg = SEG_E;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seq_display.sv
// Detection counter, one-hot state check and 4-digit multiplexed display driver
// for the five-state sequence detector.
module seq_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  seq_display_if.slave bus
);

  localparam int             CW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  REF_TC = CW'(REFRESH_DIV - 1);

  bcd3_t            cnt_q;
  bcd3_t            cnt_inc;
  logic             carry_ones;
  logic             carry_tens;
  logic [CW-1:0]    ref_q;
  logic [IDX_W-1:0] idx_q;
  logic             state_err_q;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  logic             onehot;
  logic [3:0]       letter;
  logic [3:0]       dec_code;
  logic             dec_blank;
  logic             dec_dash;
  logic [6:0]       dec_seg;

  always_comb begin
    carry_ones   = (cnt_q.ones == 4'd9);
    carry_tens   = carry_ones && (cnt_q.tens == 4'd9);
    cnt_inc.ones = bcd_digit_inc(cnt_q.ones, 1'b1);
    cnt_inc.tens = bcd_digit_inc(cnt_q.tens, carry_ones);
    cnt_inc.hund = bcd_digit_inc(cnt_q.hund, carry_tens);
  end

  // clr outranks a simultaneous detection; 999 wraps silently to 000
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (bus.clr) begin
      cnt_q <= '0;
    end else if (bus.step && bus.z) begin
      cnt_q <= cnt_inc;
    end
  end

  always_comb begin
    onehot = (bus.State != 5'b0) && ((bus.State & (bus.State - 5'd1)) == 5'b0);
    letter = CODE_A;
    case (bus.State)
      5'b00001: letter = CODE_A;
      5'b00010: letter = CODE_B;
      5'b00100: letter = CODE_C;
      5'b01000: letter = CODE_D;
      5'b10000: letter = CODE_E;
      default:  letter = CODE_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_err_q <= 1'b0;
    end else begin
      state_err_q <= !onehot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q <= '0;
      idx_q <= DIG_ONES;
    end else if (ref_q == REF_TC) begin
      ref_q <= '0;
      idx_q <= idx_q + 1'b1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  // Leading-zero blanking applies to hundreds and tens only
  always_comb begin
    dec_code  = cnt_q.ones;
    dec_blank = 1'b0;
    dec_dash  = 1'b0;
    case (idx_q)
      DIG_ONES: begin
        dec_code = cnt_q.ones;
      end
      DIG_TENS: begin
        dec_code  = cnt_q.tens;
        dec_blank = (cnt_q.hund == 4'd0) && (cnt_q.tens == 4'd0);
      end
      DIG_HUNDS: begin
        dec_code  = cnt_q.hund;
        dec_blank = (cnt_q.hund == 4'd0);
      end
      default: begin
        dec_code = letter;
        dec_dash = !onehot;
      end
    endcase
  end

  seg7_decode u_decode (
    .code  (dec_code),
    .blank (dec_blank),
    .dash  (dec_dash),
    .seg   (dec_seg)
  );

  // seg and an share one register stage so they always switch together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= dec_seg;
      an_q  <= an_pattern(idx_q);
    end
  end

  assign bus.det_count = cnt_q;
  assign bus.state_err = state_err_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = 1'b1;

endmodule

// File: doc/seq_display.md
# seq_display

Downstream display stage for the five-state one-hot sequence detector. It counts detections, meaning steps on which `z` is high, in a 3-digit BCD counter that wraps. It drives a 4-digit multiplexed active-low seven-segment display: the current state letter (A–E) goes on the leftmost digit and the detection count goes on the right three digits. It also flags any `State` vector that is not exactly one-hot.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles each digit stays lit; legal range ≥ 2.
- `clk`  in  1: system clock; all flops use the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `step`  in  1: one-cycle strobe, high in the first clk cycle after the detector enters a new state.
- `z`  in  1: detector output; sampled only while `step` is high.
- `State`  in  5: detector one-hot state, where bit 0 = A and bit 4 = E.
- `clr`  in  1: synchronous clear of the detection count.
- `det_count`  out  12: BCD count {hundreds, tens, ones}.
- `state_err`  out  1: registered; high when `State` is not exactly one-hot.
- `seg`  out  7: active-low segments {g,f,e,d,c,b,a}.
- `an`  out  4: active-low digit enables; an[3] is the leftmost digit.
- `dp`  out  1: decimal point; held 1 (off).

## Operation
- Detection counter:
  - On a cycle with `step`=1 and `z`=1, add 1 in BCD. Each digit rolls 9→0 with a carry into the next digit.
  - 999 + 1 → 000; no flag is raised.
  - `clr`=1 forces 000 and takes priority over a simultaneous increment.
  - `z` is ignored when `step`=0. Consecutive steps with `z` high (for example C→C) each count once.
- State decode: popcount(`State`)==1 selects letter A, b, C, d or E. Any other vector (zero or multiple bits) shows a dash and sets `state_err`.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - Digit index 0 = ones, 1 = tens, 2 = hundreds, 3 = state letter.
  - `an` is low only at bit [index].
- Leading-zero blanking:
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when both hundreds and tens are 0.
  - Ones digit is never blank.
- Segment codes (seg = {g..a}):
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Letters: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110.
  - Dash=0111111, blank=1111111.

## Timing
- Reset (`reset` low, asynchronous):
  - `det_count`=000, `state_err`=0.
  - Refresh counter and digit index = 0.
  - `seg`=1111111, `an`=1111, `dp`=1.
- First rising edge after `reset` goes high: `an`=1110 and `seg` shows the ones digit.
- `det_count` updates on the edge ending the `step` cycle, so latency is 1 cycle.
- `state_err` is registered from `State`, so latency is 1 cycle.
- `seg`/`an` are registered from the digit index, count and State decode.
  - Content lags its source by 1 cycle.
  - `an` and `seg` always change on the same edge, so there is no ghosting cycle.
- Each digit is lit for exactly REFRESH_DIV cycles; one full frame is 4×REFRESH_DIV cycles.
- If `reset` is asserted mid-scan, all registers return to reset values immediately and scanning restarts at digit 0.

## Structure
- Shared package `seg7_pkg`:
  - Active-low segment constants for 0–9, A, b, C, d, E, dash and blank.
  - Digit-index width and the `an` patterns.
- Sub-module `seg7_decode`: combinational; maps a 4-bit digit or letter code plus blank/dash selects to a 7-bit active-low pattern.
- Top level holds the BCD counter, refresh counter, digit index, state decoder and output registers.

## Test plan
Run the bench with REFRESH_DIV=4.
- Reset, then run 16 cycles with no `step` → `det_count`=000 and `an` cycles 1110, 1101, 1011, 0111 with 4 cycles each. Ones digit shows 1000000; tens and hundreds show 1111111. Digit 3 shows letter A (0001000) when `State`=00001.
- 12 steps with `z`=1 and 3 steps with `z`=0 → `det_count`=0x012. Tens digit shows 1111001; hundreds stays blank.
- Preload 998 via 998 steps, then 2 more steps with `z`=1 → 999, then 000; `state_err` stays 0.
- `clr` and `step`/`z`=1 in the same cycle with count 0x045 → next cycle `det_count`=000.
- `State`=00110, then 00000, then 01000 → `state_err` is 1, then 1, then 0, each one cycle later. Digit 3 shows 0111111, 0111111, then 0100001.
- Assert `reset` on the second cycle of digit 2 with count 0x123 → `seg`=1111111 and `an`=1111 with no clock edge. After release, the first digit lit is ones, and `det_count`=000.
